seq_pattern_gen: RTL

- Synthesizable stimulus generator that drives the a, b, c, d, e control lines with protocol-legal temporal patterns: consecutive repetition, goto repetition, intersect and until.
- It is the producing end of the property-checked a..e interface. It feeds the assertion-bearing checker module so that each property class receives a known-good pattern.
- Each pattern is launched by a single-cycle start. Mode and counts are latched at launch.

---
 rtl/seq_pattern_gen_pkg.sv | 25 ++
 rtl/seq_pattern_gen_if.sv | 36 +++
 rtl/seq_pattern_gen_cnt.sv | 30 +++
 rtl/seq_pattern_gen.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pattern_gen_pkg.sv
// Shared types and constants for the a..e temporal pattern generator.
package seq_pattern_pkg;

    // Pattern selected at launch.
    typedef enum logic [1:0] {
        MODE_CONSEC    = 2'd0,
        MODE_GOTO      = 2'd1,
        MODE_INTERSECT = 2'd2,
        MODE_UNTIL     = 2'd3
    } mode_e;

    // Sequencer phases; the encoding is what the debug state output shows.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEAD = 3'd1,
        BODY = 3'd2,
        GAP  = 3'd3,
        TAIL = 3'd4,
        FIN  = 3'd5
    } state_e;

    // Fixed length of the INTERSECT pattern in cycles.
    localparam int INTERSECT_LEN = 4;

endpackage

// File: rtl/seq_pattern_gen_if.sv
// Command/response bundle between a pattern requester and the generator.
//
// Handshake: start is a single-cycle request that the generator samples only
// while idle (busy=0 and done=0); mode, rep_cnt and gap are captured on the
// same edge. busy is high for every pattern cycle, done pulses for one cycle
// after the last pattern cycle, and a request is accepted again from the
// cycle after done. dbg_state mirrors the sequencer state register.
interface seq_pattern_gen_if #(
    parameter int CNT_W = 4,
    parameter int GAP_W = 3
);
    logic             start;
    logic [1:0]       mode;
    logic [CNT_W-1:0] rep_cnt;
    logic [GAP_W-1:0] gap;
    logic             busy;
    logic             done;
    logic             a;
    logic             b;
    logic             c;
    logic             d;
    logic             e;
    logic [2:0]       dbg_state;

    // Requester side.
    modport master (
        output start, mode, rep_cnt, gap,
        input  busy, done, a, b, c, d, e, dbg_state
    );

    // Generator side.
    modport slave (
        input  start, mode, rep_cnt, gap,
        output busy, done, a, b, c, d, e, dbg_state
    );
endinterface

// File: rtl/seq_pattern_gen_cnt.sv
// Loadable down-counter that saturates at zero instead of wrapping.
module seq_pattern_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    // Load wins over decrement; decrement stops at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// Temporal pattern generator for the a..e control lines: consecutive
// repetition, goto repetition, intersect and until. Every output is a flop
// whose next value is computed together with the next state.
module seq_pattern_gen
    import seq_pattern_pkg::*;
#(
    parameter int CNT_W = 4,
    parameter int GAP_W = 3
) (
    input  logic                clk,
    input  logic                reset,
    seq_pattern_gen_if.slave    bus
);

    localparam logic [2:0] ST_IDLE = IDLE;
    localparam logic [2:0] ST_LEAD = LEAD;
    localparam logic [2:0] ST_BODY = BODY;
    localparam logic [2:0] ST_GAP  = GAP;
    localparam logic [2:0] ST_TAIL = TAIL;
    localparam logic [2:0] ST_FIN  = FIN;

    logic [2:0]       state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             c_q, c_d;
    logic             d_q, d_d;
    logic             e_q, e_d;

    logic             rep_load, rep_dec, rep_zero;
    logic [CNT_W-1:0] rep_val, rep_cnt;
    logic             gap_load, gap_dec, gap_zero;
    logic [GAP_W-1:0] gap_val, gap_cnt;
    logic [CNT_W-1:0] eff_n;
    mode_e            req_mode;

    assign req_mode = mode_e'(bus.mode);
    // A requested count of zero behaves like one.
    assign eff_n    = (bus.rep_cnt == '0) ? CNT_W'(1) : bus.rep_cnt;

    // Repetition counter: b repeats (CONSEC/GOTO), a cycles (UNTIL) or
    // intersect body cycles.
    seq_pattern_cnt #(.W(CNT_W)) u_rep_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (rep_load),
        .load_val_i (rep_val),
        .dec_i      (rep_dec),
        .cnt_o      (rep_cnt),
        .zero_o     (rep_zero)
    );

    // Gap counter: rests at the captured gap between GOTO gaps, counts down
    // through a gap and is reloaded when the gap ends.
    seq_pattern_cnt #(.W(GAP_W)) u_gap_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (gap_load),
        .load_val_i (gap_val),
        .dec_i      (gap_dec),
        .cnt_o      (gap_cnt),
        .zero_o     (gap_zero)
    );

    // Next state, counter controls and next values of every output.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        gap_d    = gap_q;
        done_d   = 1'b0;
        a_d      = 1'b0;
        b_d      = 1'b0;
        c_d      = 1'b0;
        d_d      = 1'b0;
        e_d      = 1'b0;
        rep_load = 1'b0;
        rep_val  = eff_n;
        rep_dec  = 1'b0;
        gap_load = 1'b0;
        gap_val  = gap_q;
        gap_dec  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d  = ST_LEAD;
                    mode_d   = req_mode;
                    gap_d    = bus.gap;
                    rep_load = 1'b1;
                    rep_val  = (req_mode == MODE_INTERSECT)
                               ? CNT_W'(INTERSECT_LEN - 2) : eff_n;
                    gap_load = 1'b1;
                    gap_val  = bus.gap;
                    a_d      = 1'b1;
                    c_d      = (req_mode == MODE_INTERSECT);
                end
            end

            ST_LEAD: begin
                state_d = ST_BODY;
                case (mode_q)
                    MODE_CONSEC,
                    MODE_GOTO:      b_d = 1'b1;
                    MODE_INTERSECT: d_d = 1'b1;
                    MODE_UNTIL: begin
                        // Counter now tracks a cycles still owed after t0.
                        rep_dec = 1'b1;
                        if (rep_cnt == CNT_W'(1)) b_d = 1'b1;
                        else                      a_d = 1'b1;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end

            ST_BODY: begin
                case (mode_q)
                    MODE_CONSEC: begin
                        if (rep_cnt == CNT_W'(1)) begin
                            state_d = ST_FIN;
                            done_d  = 1'b1;
                        end else begin
                            rep_dec = 1'b1;
                            b_d     = 1'b1;
                        end
                    end
                    MODE_GOTO: begin
                        if (rep_cnt == CNT_W'(1)) begin
                            state_d = ST_TAIL;
                            c_d     = 1'b1;
                        end else begin
                            rep_dec = 1'b1;
                            if (gap_zero) b_d     = 1'b1;
                            else          state_d = ST_GAP;
                        end
                    end
                    MODE_INTERSECT: begin
                        if (rep_cnt == CNT_W'(1)) begin
                            state_d = ST_TAIL;
                            b_d     = 1'b1;
                            e_d     = 1'b1;
                        end else begin
                            rep_dec = 1'b1;
                        end
                    end
                    MODE_UNTIL: begin
                        if (rep_zero) begin
                            state_d = ST_FIN;
                            done_d  = 1'b1;
                        end else begin
                            rep_dec = 1'b1;
                            if (rep_cnt == CNT_W'(1)) b_d = 1'b1;
                            else                      a_d = 1'b1;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end

            ST_GAP: begin
                if (gap_cnt <= GAP_W'(1)) begin
                    state_d  = ST_BODY;
                    b_d      = 1'b1;
                    gap_load = 1'b1;
                end else begin
                    gap_dec = 1'b1;
                end
            end

            ST_TAIL: begin
                state_d = ST_FIN;
                done_d  = 1'b1;
            end

            ST_FIN: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_LEAD) || (state_d == ST_BODY) ||
                 (state_d == ST_GAP)  || (state_d == ST_TAIL);
    end

    // State, captured launch parameters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_CONSEC;
            gap_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            c_q     <= 1'b0;
            d_q     <= 1'b0;
            e_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            gap_q   <= gap_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
            e_q     <= e_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.c         = c_q;
    assign bus.d         = d_q;
    assign bus.e         = e_q;
    assign bus.dbg_state = state_q;

endmodule
